// File: rtl/sipo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sipo_pkg : shared constants for the SIPO framer and its output buffer |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package sipo_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  localparam logic ORDER_LSB = 1'b0;
  localparam logic ORDER_MSB = 1'b1;

  // Counter must also represent NUM_BEATS itself (the stalled-full value).
  function automatic int cnt_width(input int beats);
    return $clog2(beats + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_out_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sipo_out_buf : single-entry valid/ready holding register with "free"  |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module sipo_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_done,
  output logic             o_free
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_done;

  // The caller must only load when free; a load in the draining cycle keeps valid high.
  assign o_free  = !r_valid || i_ready;
  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_done  = r_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= i_load;
      if (i_load) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sipo_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sipo_framer : assembles SIZE_DATA_IN-bit beats into SIZE_DATA_OUT words|
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module sipo_framer
  import sipo_pkg::*;
#(
  parameter  int SIZE_DATA_IN  = 2,
  parameter  int SIZE_DATA_OUT = 8,
  localparam int NUM_BEATS     = SIZE_DATA_OUT / SIZE_DATA_IN,
  localparam int CNT_W         = cnt_width(NUM_BEATS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_clear,
  input  logic                     i_msb_first,
  input  logic                     i_valid,
  input  logic [SIZE_DATA_IN-1:0]  i_data,
  output logic                     o_in_ready,
  output logic [SIZE_DATA_OUT-1:0] o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_done,
  output logic [CNT_W-1:0]         o_count
);

  if ((SIZE_DATA_IN < 1) || (SIZE_DATA_OUT % SIZE_DATA_IN) != 0) begin : g_bad_params
    $error("sipo_framer: SIZE_DATA_OUT must be a positive multiple of SIZE_DATA_IN");
  end

  logic [1:0]               r_state;
  logic [CNT_W-1:0]         r_count;
  logic [SIZE_DATA_OUT-1:0] r_shift;
  logic                     r_order;

  logic                     w_accept;
  logic                     w_last;
  logic                     w_order;
  logic [CNT_W-1:0]         w_slot;
  logic [SIZE_DATA_OUT-1:0] w_word;
  logic                     w_free;
  logic                     w_load;
  logic [SIZE_DATA_OUT-1:0] w_load_data;

  assign o_in_ready = (r_state != S_STALL);
  assign o_count    = r_count;
  assign w_accept   = i_start && i_valid && o_in_ready && !i_clear;
  assign w_last     = (r_count == CNT_W'(NUM_BEATS - 1));

  // The first beat of a frame uses the live order input; later beats the latched one.
  assign w_order = (r_count == '0) ? i_msb_first : r_order;
  assign w_slot  = (w_order == ORDER_MSB) ? (CNT_W'(NUM_BEATS - 1) - r_count) : r_count;

  always_comb begin
    w_word = r_shift;
    for (int b = 0; b < NUM_BEATS; b++) begin
      if (CNT_W'(b) == w_slot) begin
        w_word[b*SIZE_DATA_IN +: SIZE_DATA_IN] = i_data;
      end
    end
  end

  assign w_load = !i_clear &&
                  (((r_state == S_STALL) && w_free) || (w_accept && w_last && w_free));
  assign w_load_data = (r_state == S_STALL) ? r_shift : w_word;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_shift <= '0;
      r_order <= ORDER_LSB;
    end else if (i_clear) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_shift <= '0;
    end else if (r_state == S_STALL) begin
      if (w_free) begin
        r_state <= S_IDLE;
        r_count <= '0;
        r_shift <= '0;
      end
    end else if (w_accept) begin
      if (r_count == '0) begin
        r_order <= i_msb_first;
      end
      if (!w_last) begin
        r_state <= S_FILL;
        r_count <= r_count + 1'b1;
        r_shift <= w_word;
      end else if (w_free) begin
        r_state <= S_IDLE;
        r_count <= '0;
        r_shift <= '0;
      end else begin
        // Park the completed word here until the holding register drains.
        r_state <= S_STALL;
        r_count <= CNT_W'(NUM_BEATS);
        r_shift <= w_word;
      end
    end
  end

  sipo_out_buf #(
    .WIDTH (SIZE_DATA_OUT)
  ) u_out_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_done  (o_done),
    .o_free  (w_free)
  );

endmodule
`default_nettype wire

// File: tb/tb_sipo_framer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_sipo_framer : directed and randomized bench for sipo_framer        |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_sipo_framer;

  localparam int DI = 2;
  localparam int DO = 8;
  localparam int NB = DO / DI;
  localparam int CW = $clog2(NB + 1);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          msb   = 1'b0;
  logic          valid = 1'b0;
  logic          ready = 1'b0;
  logic [DI-1:0] data  = '0;
  logic          in_ready;
  logic          out_valid;
  logic          done;
  logic [DO-1:0] out_data;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sipo_framer #(
    .SIZE_DATA_IN  (DI),
    .SIZE_DATA_OUT (DO)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_clear     (clear),
    .i_msb_first (msb),
    .i_valid     (valid),
    .i_data      (data),
    .o_in_ready  (in_ready),
    .o_data      (out_data),
    .o_valid     (out_valid),
    .i_ready     (ready),
    .o_done      (done),
    .o_count     (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DI-1:0] d);
    valid = 1'b1;
    data  = d;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", done); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h expected 00", out_data); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", count); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_lsb_basic();
    logic [CW-1:0] exp_cnt [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    ready = 1'b1; msb = 1'b0; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_beat(2'b10);
      n_cmp++; if (count !== exp_cnt[i]) begin n_err++; $display("FAIL lsb_count%0d: got %0d expected %0d", i, count, exp_cnt[i]); end
      if (i < 3) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lsb_early_valid%0d: got %b expected 0", i, out_valid); end
      end
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lsb_valid: got %b expected 1", out_valid); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL lsb_done: got %b expected 1", done); end
    n_cmp++; if (out_data !== 8'hAA) begin n_err++; $display("FAIL lsb_data: got %h expected aa", out_data); end
    valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lsb_valid_drop: got %b expected 0", out_valid); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL lsb_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_bit_order();
    logic [DI-1:0] pat [4] = '{2'b11, 2'b00, 2'b11, 2'b00};
    ready = 1'b1; start = 1'b1;
    msb = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(pat[i]);
    n_cmp++; if (out_data !== 8'hCC) begin n_err++; $display("FAIL order_msb: got %h expected cc", out_data); end
    valid = 1'b0; tick();
    msb = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(pat[i]);
    n_cmp++; if (out_data !== 8'h33) begin n_err++; $display("FAIL order_lsb: got %h expected 33", out_data); end
    valid = 1'b0; tick();
    msb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) msb = 1'b0;
      send_beat(pat[i]);
    end
    n_cmp++; if (out_data !== 8'hCC) begin n_err++; $display("FAIL order_toggle: got %h expected cc", out_data); end
    valid = 1'b0; tick();
  endtask

  task automatic test_backpressure();
    logic [DI-1:0] cc_lsb [4] = '{2'b00, 2'b11, 2'b00, 2'b11};
    ready = 1'b0; msb = 1'b0; start = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(2'b10);
    n_cmp++; if (out_data !== 8'hAA || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_first: got %h/%b expected aa/1", out_data, out_valid); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_before%0d: got %b expected 1", i, in_ready); end
      send_beat(cc_lsb[i]);
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); end
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL bp_count_full: got %0d expected 4", count); end
    valid = 1'b0;
    tick();
    n_cmp++; if (out_data !== 8'hAA || done !== 1'b0) begin n_err++; $display("FAIL bp_hold: got %h/%b expected aa/0", out_data, done); end
    ready = 1'b1;
    tick();
    n_cmp++; if (out_data !== 8'hCC || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_second: got %h/%b expected cc/1", out_data, out_valid); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL bp_done: got %b expected 1", done); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_back: got %b expected 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_pause();
    ready = 1'b1; msb = 1'b0; start = 1'b1;
    send_beat(2'b00);
    send_beat(2'b00);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_beat(DI'($urandom));
      n_cmp++; if (count !== 3'd2 || out_valid !== 1'b0) begin n_err++; $display("FAIL pause_hold%0d: got %0d/%b expected 2/0", i, count, out_valid); end
    end
    start = 1'b1;
    send_beat(2'b11);
    send_beat(2'b11);
    n_cmp++; if (out_data !== 8'hF0 || out_valid !== 1'b1) begin n_err++; $display("FAIL pause_resume: got %h/%b expected f0/1", out_data, out_valid); end
    valid = 1'b0; tick();
  endtask

  task automatic test_clear();
    ready = 1'b1; msb = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(2'b10);
    clear = 1'b1; send_beat(2'b10); clear = 1'b0;
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL clr_empty: got %0d/%b expected 0/0", count, out_valid); end
    ready = 1'b0;
    send_beat(2'b11); send_beat(2'b00); send_beat(2'b11); send_beat(2'b00);
    for (int i = 0; i < 3; i++) send_beat(2'b10);
    clear = 1'b1; send_beat(2'b10); clear = 1'b0;
    n_cmp++; if (count !== 3'd0 || in_ready !== 1'b1) begin n_err++; $display("FAIL clr_count: got %0d/%b expected 0/1", count, in_ready); end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h33 || done !== 1'b0) begin n_err++; $display("FAIL clr_held: got %b/%h/%b expected 1/33/0", out_valid, out_data, done); end
    for (int i = 0; i < 4; i++) send_beat(2'b01);
    valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0 || out_data !== 8'h33) begin n_err++; $display("FAIL clr_stall: got %b/%h expected 0/33", in_ready, out_data); end
    ready = 1'b1;
    tick();
    n_cmp++; if (out_data !== 8'h55 || out_valid !== 1'b1) begin n_err++; $display("FAIL clr_next: got %h/%b expected 55/1", out_data, out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clr_only_one: got %b expected 0", out_valid); end
  endtask

  task automatic test_async_reset();
    ready = 1'b0; msb = 1'b0; start = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(2'b11);
    send_beat(2'b01); send_beat(2'b01);
    valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL arst_flags: got %b/%b expected 0/0", out_valid, done); end
    n_cmp++; if (out_data !== 8'h00 || count !== 3'd0) begin n_err++; $display("FAIL arst_data: got %h/%0d expected 00/0", out_data, count); end
    tick();
    #3;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (in_ready !== 1'b1 || count !== 3'd0) begin n_err++; $display("FAIL arst_release: got %b/%0d expected 1/0", in_ready, count); end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(2'b10);
    n_cmp++; if (out_data !== 8'hAA || out_valid !== 1'b1) begin n_err++; $display("FAIL arst_fresh: got %h/%b expected aa/1", out_data, out_valid); end
    valid = 1'b0; tick(); tick();
  endtask

  // Transaction-level reference: beats collect into a frame, a full frame becomes
  // a word, and the word either enters the one-entry output buffer or waits.
  task automatic test_random();
    logic [DI-1:0] part [NB];
    int            part_n  = 0;
    logic          part_msb = 1'b0;
    logic          stalled = 1'b0;
    logic [DO-1:0] stall_word = '0;
    logic          hold_v  = 1'b0;
    logic [DO-1:0] hold_d  = '0;
    logic          exp_done;
    logic          hs, fr, ld;
    logic [DO-1:0] ld_word, w;
    int            exp_cnt;
    for (int n = 0; n < 800; n++) begin
      start = ($urandom_range(0, 9) != 0);
      valid = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 24) == 0);
      msb   = 1'($urandom);
      data  = DI'($urandom);
      ready = ($urandom_range(0, 2) != 0);
      hs = hold_v && ready;
      fr = !hold_v || ready;
      ld = 1'b0;
      ld_word = '0;
      if (clear) begin
        part_n  = 0;
        stalled = 1'b0;
      end else if (stalled) begin
        if (fr) begin ld = 1'b1; ld_word = stall_word; stalled = 1'b0; end
      end else if (start && valid) begin
        if (part_n == 0) part_msb = msb;
        part[part_n] = data;
        part_n++;
        if (part_n == NB) begin
          w = '0;
          for (int k = 0; k < NB; k++)
            w = w | (DO'(part[k]) << (part_msb ? DI * (NB - 1 - k) : DI * k));
          part_n = 0;
          if (fr) begin ld = 1'b1; ld_word = w; end
          else begin stalled = 1'b1; stall_word = w; end
        end
      end
      if (ld) begin hold_v = 1'b1; hold_d = ld_word; end
      else if (hs) hold_v = 1'b0;
      exp_done = ld;
      exp_cnt  = stalled ? NB : part_n;
      tick();
      n_cmp++; if (out_valid !== hold_v) begin n_err++; $display("FAIL rnd_valid@%0d: got %b expected %b", n, out_valid, hold_v); end
      n_cmp++; if (done !== exp_done) begin n_err++; $display("FAIL rnd_done@%0d: got %b expected %b", n, done, exp_done); end
      n_cmp++; if (count !== CW'(exp_cnt)) begin n_err++; $display("FAIL rnd_count@%0d: got %0d expected %0d", n, count, exp_cnt); end
      n_cmp++; if (in_ready !== !stalled) begin n_err++; $display("FAIL rnd_in_ready@%0d: got %b expected %b", n, in_ready, !stalled); end
      if (hold_v) begin
        n_cmp++; if (out_data !== hold_d) begin n_err++; $display("FAIL rnd_data@%0d: got %h expected %h", n, out_data, hold_d); end
      end
    end
    clear = 1'b0; valid = 1'b0; ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_lsb_basic();
    test_bit_order();
    test_backpressure();
    test_pause();
    test_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
